seg_frame_gen: RTL and testbench

- Upstream feeder for the serial display shifter on the SWORD board. Turns a 32-bit hex value plus per-digit decimal-point and blank masks into a 64-bit active-low 7-segment frame.
- Presents the frame on `data` and raises `sync` to request a load, then tracks the shifter's `sen` idle flag until the shift completes.
- Refreshes periodically and on demand. Never changes `data` while a shift is in progress.

---
 rtl/seg_frame_gen.sv | 206 ++++++++++++++++++++
 tb/tb_seg_frame_gen.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_gen.sv
// seg_frame_gen: turns a 32-bit hex value plus decimal-point and blank masks
// into a 64-bit active-low 7-segment frame, hands it to the serial display
// shifter with a sync pulse, and follows the shifter's sen flag until the
// shift is over. data is only ever rewritten in S_COMMIT or by reset.
//
// state        | meaning
// S_IDLE       | wait for a pending request while the shifter reports idle
// S_ENCODE     | encode one digit per cycle (0..7) into the shadow frame
// S_COMMIT     | copy the shadow frame onto data
// S_SYNC       | hold sync high for SYNC_HOLD cycles
// S_WAIT_START | wait (bounded by START_TIMEOUT) for the shifter to drop sen
// S_WAIT_DONE  | wait for sen to return high, then pulse frame_done
module seg_frame_gen #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int SYNC_HOLD      = 4,
  parameter int START_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] hex,
  input  logic [7:0]  dp_en,
  input  logic [7:0]  blank,
  input  logic        update,
  input  logic        sen,
  output logic [63:0] data,
  output logic        sync,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam int RW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TMAX = (SYNC_HOLD > START_TIMEOUT) ? SYNC_HOLD : START_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(SYNC_HOLD);
  localparam logic [TW-1:0] TOUT_LD  = TW'(START_TIMEOUT);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENCODE,
    S_COMMIT,
    S_SYNC,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [RW-1:0] r_ref_cnt;
  logic          r_pending;
  logic [2:0]    r_dig;
  logic [TW-1:0] r_tmr;
  logic [31:0]   r_hex_s;
  logic [7:0]    r_dp_s;
  logic [7:0]    r_blank_s;
  logic [63:0]   r_shadow;
  logic [63:0]   r_data;
  logic          r_frame_done;
  logic          r_timeout_err;

  logic          w_accept;
  logic          w_wrap;
  logic          w_tmr_last;
  logic [3:0]    w_nib;
  logic [7:0]    w_seg;
  logic [7:0]    w_byte;

  assign w_accept   = (r_state == S_IDLE) && r_pending && sen;
  assign w_wrap     = (r_ref_cnt == REF_LAST);
  assign w_tmr_last = (r_tmr == TMR_ONE);

  assign data        = r_data;
  assign frame_done  = r_frame_done;
  assign timeout_err = r_timeout_err;

  // Free-running refresh counter; wraps and update requests collapse into one pending flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ref_cnt <= '0;
      r_pending <= 1'b1;
    end else begin
      r_ref_cnt <= w_wrap ? '0 : r_ref_cnt + 1'b1;
      if (w_accept)
        r_pending <= 1'b0;
      else if (w_wrap || update)
        r_pending <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_accept) w_next = S_ENCODE;
      S_ENCODE:     if (r_dig == 3'd7) w_next = S_COMMIT;
      S_COMMIT:     w_next = S_SYNC;
      S_SYNC:       if (w_tmr_last) w_next = S_WAIT_START;
      S_WAIT_START: begin
        if (!sen)
          w_next = S_WAIT_DONE;
        else if (w_tmr_last)
          w_next = S_IDLE;
      end
      S_WAIT_DONE:  if (sen) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    sync = (r_state == S_SYNC);
    busy = (r_state != S_IDLE);
  end

  // Segment lookup for the digit currently being encoded
  always_comb begin
    w_nib = r_hex_s[{r_dig, 2'b00} +: 4];
    w_seg = 8'hFF;
    case (w_nib)
      4'h0: w_seg = 8'hC0;
      4'h1: w_seg = 8'hF9;
      4'h2: w_seg = 8'hA4;
      4'h3: w_seg = 8'hB0;
      4'h4: w_seg = 8'h99;
      4'h5: w_seg = 8'h92;
      4'h6: w_seg = 8'h82;
      4'h7: w_seg = 8'hF8;
      4'h8: w_seg = 8'h80;
      4'h9: w_seg = 8'h90;
      4'hA: w_seg = 8'h88;
      4'hB: w_seg = 8'h83;
      4'hC: w_seg = 8'hC6;
      4'hD: w_seg = 8'hA1;
      4'hE: w_seg = 8'h86;
      4'hF: w_seg = 8'h8E;
    endcase
    w_byte = w_seg;
    if (r_dp_s[r_dig])
      w_byte[7] = 1'b0;
    if (r_blank_s[r_dig])
      w_byte = 8'hFF;
  end

  // Snapshot inputs on accept, then build the shadow frame one digit per cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dig     <= '0;
      r_hex_s   <= '0;
      r_dp_s    <= '0;
      r_blank_s <= '0;
      r_shadow  <= '1;
    end else if (w_accept) begin
      r_dig     <= '0;
      r_hex_s   <= hex;
      r_dp_s    <= dp_en;
      r_blank_s <= blank;
    end else if (r_state == S_ENCODE) begin
      r_shadow[{r_dig, 3'b000} +: 8] <= w_byte;
      r_dig                          <= r_dig + 1'b1;
    end
  end

  // Shared down-counter: sync hold time first, then the start timeout
  always_ff @(posedge clk) begin
    if (!rstn)
      r_tmr <= '0;
    else if (r_state == S_COMMIT)
      r_tmr <= HOLD_LD;
    else if ((r_state == S_SYNC) && w_tmr_last)
      r_tmr <= TOUT_LD;
    else if (r_tmr != '0)
      r_tmr <= r_tmr - 1'b1;
  end

  // Visible frame only moves in COMMIT so the shifter never sees a half-built frame
  always_ff @(posedge clk) begin
    if (!rstn)
      r_data <= '1;
    else if (r_state == S_COMMIT)
      r_data <= r_shadow;
  end

  // Completion pulse and sticky start-timeout flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_frame_done <= (r_state == S_WAIT_DONE) && sen;
      if ((r_state == S_WAIT_START) && sen && w_tmr_last)
        r_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_frame_gen.sv
// Bench for seg_frame_gen: table vectors, directed timing sequences, and a
// random phase checked by a frame-content monitor plus a shifter model.
module tb_seg_frame_gen;

  localparam int REFRESH = 2000;
  localparam int HOLD    = 4;
  localparam int LAT     = 10;

  localparam logic [7:0] SEG_TBL [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] hex = '0;
  logic [7:0]  dp_en = '0;
  logic [7:0]  blank = '0;
  logic        update = 1'b0;
  logic        sen = 1'b1;
  logic [63:0] data;
  logic        sync, busy, frame_done, timeout_err;

  int          errs = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned sen_rise_cyc = 0;
  int          nframes = 0;
  bit          shf_on = 1'b0;
  bit          mon_en = 1'b0;

  seg_frame_gen #(.REFRESH_CYCLES(REFRESH)) dut (
    .clk(clk), .rstn(rstn), .hex(hex), .dp_en(dp_en), .blank(blank),
    .update(update), .sen(sen), .data(data), .sync(sync), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Reference frame: digit i from nibble i, dp clears bit 7, blank forces all off
  function automatic logic [63:0] ref_frame(input logic [31:0] h, input logic [7:0] dp,
                                            input logic [7:0] bl);
    logic [63:0] f;
    logic [7:0]  b;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      b = SEG_TBL[h[4*i +: 4]];
      if (dp[i]) b = b & 8'h7F;
      if (bl[i]) b = 8'hFF;
      f[8*i +: 8] = b;
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    step();
    update = 1'b0;
  endtask

  // sel: 0 sync high, 1 busy low, 2 frame_done, 3 sen low, 4 sync low, else busy high
  task automatic wait_for(input int sel, input int limit, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n <= limit) begin
      @(negedge clk);
      case (sel)
        0:       hit = sync;
        1:       hit = !busy;
        2:       hit = frame_done;
        3:       hit = !sen;
        4:       hit = !sync;
        default: hit = busy;
      endcase
      if (!hit) n++;
    end
    if (!hit) begin
      checks++;
      errs++;
      $display("FAIL wait_%0d: no event within %0d cycles", sel, limit);
    end
  endtask

  // Shifter model: sen drops 3 cycles after sync falls, returns 16 cycles later
  logic shf_ps = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (shf_on && shf_ps && !sync) begin
        repeat (3) @(posedge clk);
        #1;
        sen = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        sen = 1'b1;
        sen_rise_cyc = cyc;
        shf_ps = 1'b0;
      end else begin
        shf_ps = sync;
      end
    end
  end

  // Monitor: every frame must encode the inputs seen LAT cycles before sync rises,
  // data may only move on that cycle or after reset, and sync lasts HOLD cycles
  logic [31:0] h_hex [16];
  logic [7:0]  h_dp  [16];
  logic [7:0]  h_bl  [16];
  logic [63:0] p_data = '1;
  logic        p_sync = 1'b0;
  logic        p_rstn = 1'b0;
  int          run = 0;
  int unsigned back;

  always @(negedge clk) begin
    h_hex[cyc[3:0]] = hex;
    h_dp[cyc[3:0]]  = dp_en;
    h_bl[cyc[3:0]]  = blank;
    if (mon_en) begin
      if (p_rstn) begin
        checks++;
        if (data !== p_data && !(sync && !p_sync)) begin
          errs++;
          $display("FAIL data_stable cyc=%0d: got %h previously %h", cyc, data, p_data);
        end
      end
      if (sync && !p_sync) begin
        back = cyc - LAT;
        check("frame_content", data, ref_frame(h_hex[back[3:0]], h_dp[back[3:0]], h_bl[back[3:0]]));
        nframes++;
      end
      if (sync) run++;
      if (!sync && p_sync && p_rstn) check("sync_width", run, HOLD);
      if (!sync) run = 0;
    end
    p_data = data;
    p_sync = sync;
    p_rstn = rstn;
  end

  typedef struct {
    logic [31:0] hx;
    logic [7:0]  dp;
    logic [7:0]  bl;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          n;
    int          f0;
    int unsigned t0;

    // digit 7 carries hex[31:28] and lands in data[63:56]
    vecs[0] = '{32'h0123_4567, 8'h00, 8'h00, 64'hC0F9_A4B0_9992_82F8};
    vecs[1] = '{32'hFFFF_FFFF, 8'h01, 8'h80, 64'hFF8E_8E8E_8E8E_8E0E};
    vecs[2] = '{32'h89AB_CDEF, 8'h00, 8'h00, 64'h8090_8883_C6A1_868E};
    vecs[3] = '{32'h0000_0000, 8'hFF, 8'h00, 64'h4040_4040_4040_4040};
    vecs[4] = '{32'h1234_5678, 8'hAA, 8'h55, 64'h79FF_30FF_12FF_78FF};

    // Reset state
    rstn = 1'b0;
    hex  = 32'h0123_4567;
    repeat (3) step();
    @(negedge clk);
    check("rst_data", data, '1);
    check("rst_sync", sync, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    mon_en = 1'b1;

    // First frame straight after reset release, then shifter handshake timing
    step();
    shf_on = 1'b1;
    rstn = 1'b1;
    wait_for(0, 40, n);
    check("latency_after_reset", n, LAT);
    check("first_frame", data, 64'hC0F9_A4B0_9992_82F8);
    wait_for(2, 60, n);
    check("done_after_sen_rise", cyc, sen_rise_cyc + 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", frame_done, 0);

    // Three updates during WAIT_DONE give exactly one more frame; late hex changes ignored
    hex = 32'h89AB_CDEF;
    pulse_update();
    wait_for(3, 60, n);
    step(); pulse_update();
    step(); pulse_update();
    step(); pulse_update();
    hex = 32'h1357_9BDF; dp_en = 8'h0F; blank = 8'h30;
    f0 = nframes;
    wait_for(2, 60, n);
    step(); hex = 32'hDEAD_BEEF; dp_en = 8'hF0; blank = 8'h00;
    step(); hex = 32'h0000_0000; dp_en = 8'h00; blank = 8'hFF;
    wait_for(0, 40, n);
    check("encode_ignores_late_hex", data, ref_frame(32'h1357_9BDF, 8'h0F, 8'h30));
    wait_for(1, 80, n);
    repeat (150) step();
    check("collapsed_updates", nframes - f0, 1);

    // Table vectors, each requested by update
    for (int i = 0; i < 5; i++) begin
      hex = vecs[i].hx; dp_en = vecs[i].dp; blank = vecs[i].bl;
      step();
      pulse_update();
      wait_for(0, 40, n);
      check($sformatf("table_lat_%0d", i), n, LAT);
      check($sformatf("table_data_%0d", i), data, vecs[i].exp);
      wait_for(1, 80, n);
    end

    // No shifter response: start timeout, then the next automatic refresh
    shf_on = 1'b0;
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    t0 = cyc;
    wait_for(0, 40, n);
    check("to_latency", cyc, t0 + LAT);
    wait_for(4, 20, n);
    repeat (14) @(negedge clk);
    check("to_not_yet", timeout_err, 0);
    check("to_busy_wait_start", busy, 1);
    @(negedge clk);
    check("to_set", timeout_err, 1);
    check("to_back_idle", busy, 0);
    wait_for(0, REFRESH + 50, n);
    check("refresh_sync_cycle", cyc, t0 + REFRESH + LAT);
    check("to_sticky", timeout_err, 1);
    wait_for(1, 80, n);

    // Reset during ENCODE and during WAIT_DONE
    shf_on = 1'b1;
    step();
    rstn = 1'b0; hex = 32'hCAFE_F00D; dp_en = 8'h81; blank = 8'h00;
    step();
    @(negedge clk);
    check("rst2_timeout_clr", timeout_err, 0);
    step();
    rstn = 1'b1;
    t0 = cyc;
    wait_for(0, 40, n);
    check("rst2_first_sync", cyc, t0 + LAT);
    wait_for(1, 80, n);
    step();
    pulse_update();
    wait_for(5, 20, n);
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    t0 = cyc;
    @(negedge clk);
    check("rst_encode_data", data, '1);
    check("rst_encode_sync", sync, 0);
    check("rst_encode_busy", busy, 0);
    wait_for(0, 40, n);
    check("rst_encode_restart", cyc, t0 + LAT);
    wait_for(3, 40, n);
    step();
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    @(negedge clk);
    check("rst_wdone_data", data, '1);
    check("rst_wdone_sync", sync, 0);
    check("rst_wdone_busy", busy, 0);
    check("rst_wdone_frame_done", frame_done, 0);
    wait_for(0, 60, n);
    check("deferred_until_sen", cyc, sen_rise_cyc + LAT);
    wait_for(1, 80, n);

    // Random inputs and update requests, checked by the monitor
    f0 = nframes;
    for (int i = 0; i < 3000; i++) begin
      hex    = $urandom;
      dp_en  = 8'($urandom);
      blank  = 8'($urandom);
      update = ($urandom_range(0, 29) == 0);
      step();
    end
    update = 1'b0;
    wait_for(1, 80, n);
    check("random_frames_seen", (nframes - f0 >= 20), 1);
    check("random_no_timeout", timeout_err, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
